// File: rtl/ysyx_22050019_axi_burst_sram_if.sv
// ysyx_22050019_axi_burst_sram_if: AXI-style AW/W/B/AR/R bundle for the burst SRAM.
interface ysyx_22050019_axi_burst_sram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    aw_valid, aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [7:0]              aw_len;
  logic                    w_valid, w_ready, w_last;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid, b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    ar_valid, ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [7:0]              ar_len;
  logic                    r_valid, r_ready, r_last;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ID_WIDTH-1:0]     r_id;
  logic [1:0]              r_resp;
  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_id, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_id, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
endinterface

// File: rtl/ysyx_22050019_axi_burst_sram.sv
// ysyx_22050019_axi_burst_sram: INCR-burst SRAM slave with independent read/write FSMs.
// Define YSYX_AXI_SRAM_WLAST_CHK_EN to report SLVERR on misplaced w_last.
module ysyx_22050019_axi_burst_sram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 1024
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050019_axi_burst_sram_if.slave bus
);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int IW  = $clog2(DEPTH);
  localparam int NB  = DATA_WIDTH/8;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  wstate_t r_ws, w_ws_nxt;
  rstate_t r_rs, w_rs_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_widx, r_ridx, w_ar_idx, w_rd_idx;
  logic [7:0]            r_wcnt, r_wlen, r_rcnt, r_rlen;
  logic [ID_WIDTH-1:0]   r_bid, r_rid;
  logic [1:0]            r_bresp, r_rresp, w_beat_resp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rlast;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_w_oor, w_rd_oor, w_rd_ld, w_wlast_err;
  assign w_aw_hs  = bus.aw_valid && r_ws == W_IDLE;
  assign w_w_hs   = bus.w_valid && r_ws == W_DATA;
  assign w_ar_hs  = bus.ar_valid && r_rs == R_IDLE;
  assign w_r_hs   = bus.r_ready && r_rs == R_DATA;
  assign w_ar_idx = bus.ar_addr >> OFF;
  assign w_rd_idx = w_ar_hs ? w_ar_idx : r_ridx;
  assign w_rd_ld  = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_w_oor  = r_widx >= ADDR_WIDTH'(DEPTH);
  assign w_rd_oor = w_rd_idx >= ADDR_WIDTH'(DEPTH);
`ifdef YSYX_AXI_SRAM_WLAST_CHK_EN
  assign w_wlast_err = bus.w_last != (r_wcnt == r_wlen);
`else
  assign w_wlast_err = 1'b0;
`endif
  assign w_beat_resp = w_w_oor ? 2'b11 : w_wlast_err ? 2'b10 : 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws <= W_IDLE;
      r_rs <= R_IDLE;
    end else begin
      r_ws <= w_ws_nxt;
      r_rs <= w_rs_nxt;
    end
  end
  always_comb begin
    w_ws_nxt = r_ws == W_IDLE ? (bus.aw_valid ? W_DATA : W_IDLE) :
               r_ws == W_DATA ? ((bus.w_valid && r_wcnt == r_wlen) ? W_RESP : W_DATA) :
               (bus.b_ready ? W_IDLE : W_RESP);
    w_rs_nxt = r_rs == R_IDLE ? (bus.ar_valid ? R_DATA : R_IDLE) :
               ((bus.r_ready && r_rlast) ? R_IDLE : R_DATA);
  end
  always_comb begin
    bus.aw_ready = r_ws == W_IDLE;
    bus.w_ready  = r_ws == W_DATA;
    bus.b_valid  = r_ws == W_RESP;
    bus.b_id     = r_bid;
    bus.b_resp   = r_bresp;
    bus.ar_ready = r_rs == R_IDLE;
    bus.r_valid  = r_rs == R_DATA;
    bus.r_data   = r_rdata;
    bus.r_id     = r_rid;
    bus.r_resp   = r_rresp;
    bus.r_last   = r_rlast;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx  <= '0;
      r_wcnt  <= '0;
      r_wlen  <= '0;
      r_bid   <= '0;
      r_bresp <= '0;
    end else if (w_aw_hs) begin
      r_widx  <= bus.aw_addr >> OFF;
      r_wcnt  <= '0;
      r_wlen  <= bus.aw_len;
      r_bid   <= bus.aw_id;
      r_bresp <= '0;
    end else if (w_w_hs) begin
      r_widx  <= r_widx + 1'b1;
      r_wcnt  <= r_wcnt + 1'b1;
      r_bresp <= w_beat_resp > r_bresp ? w_beat_resp : r_bresp;
    end
  end
  // Array is never reset so completed writes survive an rst_n pulse.
  always_ff @(posedge clk) begin
    if (w_w_hs && !w_w_oor)
      for (int b = 0; b < NB; b++)
        if (bus.w_strb[b]) r_mem[r_widx[IW-1:0]][8*b +: 8] <= bus.w_data[8*b +: 8];
  end
  // Read data is registered from the pre-edge array, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ridx  <= '0;
      r_rcnt  <= '0;
      r_rlen  <= '0;
      r_rid   <= '0;
      r_rresp <= '0;
      r_rdata <= '0;
      r_rlast <= 1'b0;
    end else begin
      if (w_rd_ld) begin
        r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_idx[IW-1:0]];
        r_rresp <= w_rd_oor ? 2'b11 : 2'b00;
        r_ridx  <= w_rd_idx + 1'b1;
      end
      if (w_ar_hs) begin
        r_rcnt  <= '0;
        r_rlen  <= bus.ar_len;
        r_rid   <= bus.ar_id;
        r_rlast <= bus.ar_len == 8'd0;
      end else if (w_r_hs) begin
        r_rcnt  <= r_rcnt + 1'b1;
        r_rlast <= !r_rlast && (r_rcnt + 8'd1 == r_rlen);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050019_axi_burst_sram.sv
// tb_ysyx_22050019_axi_burst_sram: directed bursts with a B/R scoreboard and negedge monitor.
module tb_ysyx_22050019_axi_burst_sram;
  localparam int DW = 64, AW = 32, IDW = 4, DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  ysyx_22050019_axi_burst_sram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus();
  ysyx_22050019_axi_burst_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct packed {logic [1:0] resp; logic [IDW-1:0] id;} bexp_t;
  typedef struct packed {logic [DW-1:0] d; logic [IDW-1:0] id; logic [1:0] resp; logic last;} rexp_t;
  bexp_t bq[$];
  rexp_t rq[$];
  bexp_t eb;
  rexp_t er, ra, held;
  logic stall = 1'b0;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timed out", name);
  endtask
  always @(negedge clk) begin
    if (!rst_n) stall <= 1'b0;
    else begin
      ra = '{d: bus.r_data, id: bus.r_id, resp: bus.r_resp, last: bus.r_last};
      if (bus.b_valid && bus.b_ready) begin
        if (bq.size() == 0) timeout("unexpected_b");
        else begin
          eb = bq.pop_front();
          chk("b_id", 80'(bus.b_id), 80'(eb.id));
          chk("b_resp", 80'(bus.b_resp), 80'(eb.resp));
        end
      end
      if (bus.r_valid && stall) chk("r_hold", 80'(ra), 80'(held));
      stall <= bus.r_valid && !bus.r_ready;
      held <= ra;
      if (bus.r_valid && bus.r_ready) begin
        if (rq.size() == 0) timeout("unexpected_r");
        else begin
          er = rq.pop_front();
          chk("r_beat", 80'(ra), 80'(er));
        end
      end
    end
  end
  task automatic send_aw(input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [7:0] len);
    bit ok;
    int t = 0;
    bus.aw_addr = a; bus.aw_id = id; bus.aw_len = len; bus.aw_valid = 1'b1;
    do begin @(negedge clk); ok = bus.aw_ready; @(posedge clk); t++; end while (!ok && t < 100);
    #1 bus.aw_valid = 1'b0;
    if (!ok) timeout("aw");
  endtask
  task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l);
    bit ok;
    int t = 0;
    bus.w_data = d; bus.w_strb = s; bus.w_last = l; bus.w_valid = 1'b1;
    do begin @(negedge clk); ok = bus.w_ready; @(posedge clk); t++; end while (!ok && t < 100);
    #1 bus.w_valid = 1'b0;
    if (!ok) timeout("w");
  endtask
  task automatic send_ar(input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [7:0] len);
    bit ok;
    int t = 0;
    bus.ar_addr = a; bus.ar_id = id; bus.ar_len = len; bus.ar_valid = 1'b1;
    do begin @(negedge clk); ok = bus.ar_ready; @(posedge clk); t++; end while (!ok && t < 100);
    #1 bus.ar_valid = 1'b0;
    if (!ok) timeout("ar");
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [7:0] len,
                    input logic [DW-1:0] base, input logic [DW/8-1:0] s, input int wl);
    send_aw(a, id, len);
    for (int i = 0; i <= int'(len); i++) send_w(base + DW'(i), s, i == wl);
  endtask
  task automatic drain();
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 500) begin @(posedge clk); t++; end
    #1;
    if (bq.size() != 0 || rq.size() != 0) begin
      timeout("drain");
      bq.delete();
      rq.delete();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_id = 0; bus.aw_len = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.b_ready = 1;
    bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_id = 0; bus.ar_len = 0; bus.r_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_aw_ready", 80'(bus.aw_ready), 80'(1));
    chk("rst_ar_ready", 80'(bus.ar_ready), 80'(1));
    chk("rst_w_ready", 80'(bus.w_ready), 80'(0));
    chk("rst_b_valid", 80'(bus.b_valid), 80'(0));
    chk("rst_r_valid", 80'(bus.r_valid), 80'(0));
    chk("rst_r_last", 80'(bus.r_last), 80'(0));
    chk("rst_r_data", 80'(bus.r_data), 80'(0));
    chk("rst_resp", 80'({bus.b_resp, bus.r_resp}), 80'(0));
    chk("rst_ids", 80'({bus.b_id, bus.r_id}), 80'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // basic 4-beat write then read back
    bq.push_back('{resp: 2'b00, id: 4'd5});
    wr(32'h10, 4'd5, 8'd3, 64'hA, 8'hFF, 3);
    drain();
    for (int i = 0; i < 4; i++) rq.push_back('{d: 64'hA + 64'(i), id: 4'd6, resp: 2'b00, last: i == 3});
    send_ar(32'h10, 4'd6, 8'd3);
    drain();
    // partial strobe over all-ones word
    bq.push_back('{resp: 2'b00, id: 4'd1});
    wr(32'h40, 4'd1, 8'd0, '1, 8'hFF, 0);
    bq.push_back('{resp: 2'b00, id: 4'd2});
    wr(32'h40, 4'd2, 8'd0, 64'h1122334455667788, 8'h0F, 0);
    drain();
    rq.push_back('{d: 64'hFFFFFFFF55667788, id: 4'd3, resp: 2'b00, last: 1'b1});
    send_ar(32'h40, 4'd3, 8'd0);
    drain();
    // r_ready back-pressure
    bus.r_ready = 1'b0;
    rq.push_back('{d: 64'hA, id: 4'd9, resp: 2'b00, last: 1'b0});
    rq.push_back('{d: 64'hB, id: 4'd9, resp: 2'b00, last: 1'b1});
    send_ar(32'h10, 4'd9, 8'd1);
    for (int i = 0; i < 6; i++) begin bus.r_ready = i[0]; @(posedge clk); #1; end
    bus.r_ready = 1'b1;
    drain();
    // burst crossing the top of the array
    bq.push_back('{resp: 2'b11, id: 4'd4});
    wr(32'h78, 4'd4, 8'd1, 64'h77, 8'hFF, 1);
    drain();
    rq.push_back('{d: 64'h77, id: 4'd7, resp: 2'b00, last: 1'b0});
    rq.push_back('{d: 64'h0, id: 4'd7, resp: 2'b11, last: 1'b1});
    send_ar(32'h78, 4'd7, 8'd1);
    drain();
    // same-cycle read and write of one word
    bq.push_back('{resp: 2'b00, id: 4'd8});
    wr(32'h20, 4'd8, 8'd0, 64'h1111, 8'hFF, 0);
    drain();
    bq.push_back('{resp: 2'b00, id: 4'd9});
    send_aw(32'h20, 4'd9, 8'd0);
    rq.push_back('{d: 64'h1111, id: 4'd10, resp: 2'b00, last: 1'b1});
    fork
      send_w(64'h2222, 8'hFF, 1'b1);
      send_ar(32'h20, 4'd10, 8'd0);
    join
    drain();
    rq.push_back('{d: 64'h2222, id: 4'd11, resp: 2'b00, last: 1'b1});
    send_ar(32'h20, 4'd11, 8'd0);
    drain();
    // reset during beat 3 of a 4-beat write
    send_aw(32'h30, 4'd12, 8'd3);
    send_w(64'h61, 8'hFF, 1'b0);
    send_w(64'h62, 8'hFF, 1'b0);
    bus.w_data = 64'h63; bus.w_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_aw_ready", 80'(bus.aw_ready), 80'(1));
    chk("mid_rst_w_ready", 80'(bus.w_ready), 80'(0));
    chk("mid_rst_b_valid", 80'(bus.b_valid), 80'(0));
    bus.w_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_b_valid", 80'(bus.b_valid), 80'(0));
    rq.push_back('{d: 64'h61, id: 4'd13, resp: 2'b00, last: 1'b0});
    rq.push_back('{d: 64'h62, id: 4'd13, resp: 2'b00, last: 1'b0});
    rq.push_back('{d: 64'hFFFFFFFF55667788, id: 4'd13, resp: 2'b00, last: 1'b1});
    send_ar(32'h30, 4'd13, 8'd2);
    drain();
    // early w_last on beat 1 of 4
`ifdef YSYX_AXI_SRAM_WLAST_CHK_EN
    bq.push_back('{resp: 2'b10, id: 4'd14});
`else
    bq.push_back('{resp: 2'b00, id: 4'd14});
`endif
    wr(32'h50, 4'd14, 8'd3, 64'h100, 8'hFF, 1);
    drain();
    rq.push_back('{d: 64'h103, id: 4'd15, resp: 2'b00, last: 1'b1});
    send_ar(32'h68, 4'd15, 8'd0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
